// File: rtl/fp_pkg.sv
// Format constants and canonical encodings shared by the binary32/binary16 FP blocks.
package fp_pkg;

  localparam int EXP_W32   = 8;
  localparam int FRAC_W32  = 23;
  localparam int BIAS32    = 127;
  localparam int EXP_MAX32 = 255;

  localparam int EXP_W16   = 5;
  localparam int FRAC_W16  = 10;
  localparam int BIAS16    = 15;
  localparam int EXP_MAX16 = 31;

  localparam logic [31:0] NAN32  = 32'h7FC0_0000;
  localparam logic [31:0] INF32  = 32'h7F80_0000;
  localparam logic [31:0] MAXF32 = 32'h7F7F_FFFF;
  localparam logic [15:0] NAN16  = 16'h7E00;
  localparam logic [15:0] INF16  = 16'h7C00;
  localparam logic [15:0] MAXF16 = 16'h7BFF;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign/exponent/mantissa and class flags; binary16
// fractions are left-aligned so both formats share one 24-bit mantissa path.
module fp_unpack
  import fp_pkg::*;
(
  input  logic        mode_fp,
  input  logic [31:0] op,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] mant,
  output logic        is_zero,
  output logic        is_sub,
  output logic        is_inf,
  output logic        is_nan
);

  logic [FRAC_W32-1:0] frac;
  logic                exp_ones;

  always_comb begin
    if (mode_fp) begin
      sign     = op[31];
      exp      = op[30:23];
      frac     = op[22:0];
      exp_ones = &op[30:23];
    end else begin
      sign     = op[15];
      exp      = {3'b000, op[14:10]};
      frac     = {op[9:0], 13'b0};
      exp_ones = &op[14:10];
    end
    mant    = {1'b1, frac};
    is_zero = (exp == 8'd0) && (frac == '0);
    is_sub  = (exp == 8'd0) && (frac != '0);
    is_inf  = exp_ones && (frac == '0);
    is_nan  = exp_ones && (frac != '0);
  end

endmodule

// File: rtl/fdiv.sv
// binary32/binary16 divider: combinational divide, normalise and round, with
// only the result registered. No handshake: one operation accepted per cycle.
module fdiv
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        round_mode,
  input  logic        mode_fp,
  output logic [31:0] result
);

  logic        sa, sb, a_zr, b_zr, a_sub, b_sub, a_inf, b_inf, a_nan, b_nan;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  fp_unpack u_unpack_a (
    .mode_fp(mode_fp), .op(op_a), .sign(sa), .exp(ea), .mant(ma),
    .is_zero(a_zr), .is_sub(a_sub), .is_inf(a_inf), .is_nan(a_nan)
  );

  fp_unpack u_unpack_b (
    .mode_fp(mode_fp), .op(op_b), .sign(sb), .exp(eb), .mant(mb),
    .is_zero(b_zr), .is_sub(b_sub), .is_inf(b_inf), .is_nan(b_nan)
  );

  logic [49:0]        num, den;
  logic [26:0]        quo, norm;
  logic [23:0]        rem;
  logic               quo_lt1, guard, rnd, sticky, inc, carry, s_res;
  logic               a_zero, b_zero, is_nan;
  logic [23:0]        mant;
  logic [24:0]        sum;
  logic signed [10:0] exp_s, exp_r, exp_max;
  logic [31:0]        result_d, result_q;

  always_comb begin
    a_zero = a_zr | a_sub;
    b_zero = b_zr | b_sub;
    s_res  = sa ^ sb;
    is_nan = a_nan | b_nan | b_zero | (a_inf & b_inf);

    // Quotient lands in [2^25, 2^27): 24 mantissa bits plus guard/round/sticky
    // even after the one-bit renormalisation when ma < mb.
    num     = {ma, 26'b0};
    den     = {26'b0, mb};
    quo     = 27'(num / den);
    rem     = 24'(num % den);
    quo_lt1 = ~quo[26];
    norm    = quo[26] ? quo : {quo[25:0], 1'b0};

    exp_s = $signed({3'b000, ea}) - $signed({3'b000, eb})
          + (mode_fp ? 11'sd127 : 11'sd15) - (quo_lt1 ? 11'sd1 : 11'sd0);
    exp_max = mode_fp ? 11'sd255 : 11'sd31;

    if (mode_fp) begin
      mant   = norm[26:3];
      guard  = norm[2];
      rnd    = norm[1];
      sticky = norm[0] | (rem != '0);
    end else begin
      mant   = {13'b0, norm[26:16]};
      guard  = norm[15];
      rnd    = norm[14];
      sticky = (|norm[13:0]) | (rem != '0);
    end

    inc   = (round_mode == RM_RNE) && guard && (rnd || sticky || mant[0]);
    sum   = {1'b0, mant} + 25'(inc);
    // On carry-out the fraction bits are already zero; only the exponent moves.
    carry = mode_fp ? sum[24] : sum[11];
    exp_r = exp_s + (carry ? 11'sd1 : 11'sd0);

    if (is_nan) begin
      result_d = mode_fp ? NAN32 : {16'b0, NAN16};
    end else if (a_inf) begin
      result_d = mode_fp ? {s_res, INF32[30:0]} : {16'b0, s_res, INF16[14:0]};
    end else if (b_inf || a_zero) begin
      result_d = mode_fp ? {s_res, 31'b0} : {16'b0, s_res, 15'b0};
    end else if (exp_r >= exp_max) begin
      if (round_mode == RM_RNE)
        result_d = mode_fp ? {s_res, INF32[30:0]} : {16'b0, s_res, INF16[14:0]};
      else
        result_d = mode_fp ? {s_res, MAXF32[30:0]} : {16'b0, s_res, MAXF16[14:0]};
    end else if (exp_r <= 11'sd0) begin
      result_d = mode_fp ? {s_res, 31'b0} : {16'b0, s_res, 15'b0};
    end else begin
      result_d = mode_fp ? {s_res, exp_r[7:0], sum[22:0]}
                         : {16'b0, s_res, exp_r[4:0], sum[9:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) result_q <= 32'h0;
    else     result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_fdiv.sv
// Directed bench for fdiv: every driven op pushes its expected result, which a
// monitor pops one cycle later and compares against result.
module tb_fdiv;

  logic        clk;
  logic        rst;
  logic [31:0] op_a, op_b;
  logic        round_mode, mode_fp;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] mon_e;
  string       mon_t;

  fdiv dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b),
    .round_mode(round_mode), .mode_fp(mode_fp), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the op is taken on the next rising edge.
  task automatic send(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic rm, input logic md, input logic [31:0] e,
                      input string tag);
    @(negedge clk);
    rst        = r;
    op_a       = a;
    op_b       = b;
    round_mode = rm;
    mode_fp    = md;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic rm,
                        input logic [15:0] e, input string tag);
    logic [15:0] ua, ub;
    ua = 16'($urandom_range(0, 65535));
    ub = 16'($urandom_range(0, 65535));
    send(1'b0, {ua, a}, {ub, b}, rm, 1'b0, {16'b0, e}, tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      assert (result === mon_e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", mon_t, result, mon_e);
      end
    end
  end

  initial begin
    rst = 1'b1; op_a = '0; op_b = '0; round_mode = 1'b0; mode_fp = 1'b1;

    send(1'b1, 32'h40B00000, 32'h40000000, 1'b0, 1'b1, 32'h0, "reset_0");
    send(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h0, "reset_1");

    // fp32 RNE, back-to-back
    send(1'b0, 32'h40B00000, 32'h40000000, 1'b0, 1'b1, 32'h40300000, "f32_5.5/2");
    send(1'b0, 32'h40100000, 32'h40B00000, 1'b0, 1'b1, 32'h3ED1745D, "f32_2.25/5.5");
    send(1'b0, 32'h3FC00000, 32'h3FC00000, 1'b0, 1'b1, 32'h3F800000, "f32_equal");
    send(1'b0, 32'h3F800000, 32'h40400000, 1'b0, 1'b1, 32'h3EAAAAAB, "f32_1/3_rne");
    send(1'b0, 32'h3F800000, 32'h40400000, 1'b1, 1'b1, 32'h3EAAAAAA, "f32_1/3_rtz");

    // fp32 specials
    send(1'b0, 32'h3F800000, 32'h00000000, 1'b0, 1'b1, 32'h7FC00000, "f32_x/0");
    send(1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h7FC00000, "f32_0/0");
    send(1'b0, 32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 32'h7FC00000, "f32_inf/inf");
    send(1'b0, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000, "f32_nan_in");
    send(1'b0, 32'h7F800000, 32'h40000000, 1'b0, 1'b1, 32'h7F800000, "f32_inf/2");
    send(1'b0, 32'hFF800000, 32'h40000000, 1'b0, 1'b1, 32'hFF800000, "f32_-inf/2");
    send(1'b0, 32'hBF800000, 32'h7F800000, 1'b0, 1'b1, 32'h80000000, "f32_-1/inf");
    send(1'b0, 32'h00000001, 32'h3F800000, 1'b0, 1'b1, 32'h00000000, "f32_daz_a");
    send(1'b0, 32'h3F800000, 32'h00000001, 1'b0, 1'b1, 32'h7FC00000, "f32_daz_b");
    send(1'b0, 32'h7F000000, 32'h00800000, 1'b0, 1'b1, 32'h7F800000, "f32_ovf_rne");
    send(1'b0, 32'h7F000000, 32'h00800000, 1'b1, 1'b1, 32'h7F7FFFFF, "f32_ovf_rtz");
    send(1'b0, 32'hFF000000, 32'h00800000, 1'b1, 1'b1, 32'hFF7FFFFF, "f32_-ovf_rtz");

    // fp16, random upper bits plus one explicit all-ones upper half
    send16(16'h4580, 16'h4000, 1'b0, 16'h4180, "f16_5.5/2");
    send16(16'h4100, 16'h4580, 1'b0, 16'h3746, "f16_2.5/5.5");
    send16(16'h4080, 16'h4580, 1'b0, 16'h368C, "f16_2.25/5.5_rne");
    send16(16'h4080, 16'h4580, 1'b1, 16'h368B, "f16_2.25/5.5_rtz");
    send16(16'h3E00, 16'h3E00, 1'b0, 16'h3C00, "f16_equal");
    send16(16'hC000, 16'h4000, 1'b0, 16'hBC00, "f16_-2/2");
    send(1'b0, 32'hFFFF4580, 32'hFFFF4000, 1'b0, 1'b0, 32'h00004180, "f16_upper_ffff");
    send16(16'h3C00, 16'h0000, 1'b0, 16'h7E00, "f16_x/0");
    send16(16'h2000, 16'h7C00, 1'b0, 16'h0000, "f16_x/inf");
    send16(16'h0400, 16'h7800, 1'b0, 16'h0000, "f16_underflow");
    send16(16'h8000, 16'h3C00, 1'b0, 16'h8000, "f16_-0/1");
    send16(16'h7800, 16'h0400, 1'b0, 16'h7C00, "f16_ovf_rne");
    send16(16'h7800, 16'h0400, 1'b1, 16'h7BFF, "f16_ovf_rtz");

    // reset mid-stream discards the op presented at the reset edge
    send(1'b0, 32'h40B00000, 32'h40000000, 1'b0, 1'b1, 32'h40300000, "pre_reset");
    send(1'b1, 32'h3F800000, 32'h40400000, 1'b0, 1'b1, 32'h00000000, "mid_reset");
    send(1'b0, 32'h3FC00000, 32'h3FC00000, 1'b0, 1'b1, 32'h3F800000, "post_reset");

    @(posedge clk);
    #3;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
